// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register map, vector layout.
// No logic of its own; imported by the top and the per-source synchronizer.
// The vector helper is pure combinational arithmetic that wraps modulo 2^16.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_e;

  localparam logic [1:0] SEL_MASK = 2'd0;
  localparam logic [1:0] SEL_BASE = 2'd1;
  localparam logic [1:0] SEL_EOI  = 2'd2;
  localparam logic [1:0] SEL_PEND = 2'd3;

  localparam logic [15:0] VEC_RST_DEFAULT = 16'h0100;
  localparam logic [15:0] VEC_STRIDE      = 16'd4;
  localparam int          ID_W            = 3;

  // Handler address of source id: base plus a fixed stride per source, 16-bit wrap.
  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [ID_W-1:0] id);
    return base + (16'(id) * VEC_STRIDE);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: 2-flop synchronizer followed by a rising-edge detector.
// Latency: an edge seen by the second sync flop pulses rise for one cycle.
// No backpressure; rise is suppressed until the chain has refilled after reset.
module irq_sync_edge
  import irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src_in,
  output logic rise
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q,  prev_d;
  // Arm shift register: edges are only trusted once the synchronizer and the
  // previous-value flop all hold post-reset samples, so a line that was
  // already high at reset release is treated as a level, not an edge.
  logic [2:0] arm_q,   arm_d;

  // Next-state for the synchronizer chain, edge-detect history and arm bits.
  always_comb begin
    sync1_d = src_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    arm_d   = {arm_q[1:0], 1'b1};
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      arm_q   <= 3'b000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
    end
  end

  assign rise = sync2_q & ~prev_q & arm_q[2];

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: NSRC edge-triggered sources, one in service at a time.
// Latency: pend set 1 cycle after a synchronized edge, irq 1 cycle later; vec 1 cycle after ack.
// Flow: irq held until int_ack or withdrawal; no new request until EOI retires the current one.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC    = 8,
  parameter logic [15:0] VEC_RST = VEC_RST_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            cr_we,
  input  logic [1:0]      cr_sel,
  input  logic [15:0]     cr_wdata,
  output logic [15:0]     cr_rdata,
  output logic            irq,
  input  logic            int_ack,
  output logic [15:0]     vec,
  output logic            vec_valid
);

  state_e            state_q, state_d;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [NSRC-1:0]   mask_q, mask_d;
  logic [15:0]       base_q, base_d;
  logic [15:0]       vec_q, vec_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              irq_q, irq_d;
  logic              vec_valid_q, vec_valid_d;

  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   elig;
  logic [ID_W-1:0]   top_id;
  logic [NSRC-1:0]   ack_clr;
  logic [NSRC-1:0]   pend_clr;
  logic              wr_mask, wr_base, wr_eoi, wr_pend;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst_n  (reset),
      .src_in (src[g]),
      .rise   (rise[g])
    );
  end

  assign elig    = pend_q & mask_q;
  assign wr_mask = cr_we && (cr_sel == SEL_MASK);
  assign wr_base = cr_we && (cr_sel == SEL_BASE);
  assign wr_eoi  = cr_we && (cr_sel == SEL_EOI);
  assign wr_pend = cr_we && (cr_sel == SEL_PEND);

  // Priority encoder: scanning from the top down leaves the lowest set index.
  always_comb begin
    top_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) top_id = ID_W'(i);
    end
  end

  // FSM next state plus the acknowledge side effects (id, vector, pend clear).
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    vec_d       = vec_q;
    vec_valid_d = 1'b0;
    ack_clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (|elig) state_d = ST_REQ;
      end
      ST_REQ: begin
        // An ack that lands after the request was withdrawn is treated as stray.
        if (int_ack && (|elig)) begin
          id_d        = top_id;
          ack_clr     = NSRC'(1) << top_id;
          vec_d       = vec_addr(base_q, top_id);
          vec_valid_d = 1'b1;
          state_d     = ST_SERV;
        end else if (!(|elig)) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERV: begin
        if (wr_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d = (state_d == ST_REQ);
  end

  // Control registers; a new edge beats any clear of the same pend bit.
  always_comb begin
    mask_d   = wr_mask ? cr_wdata[NSRC-1:0] : mask_q;
    base_d   = wr_base ? {cr_wdata[15:2], 2'b00} : base_q;
    pend_clr = ack_clr | (wr_pend ? cr_wdata[NSRC-1:0] : '0);
    pend_d   = (pend_q & ~pend_clr) | rise;
  end

  // State registers, cleared asynchronously so a reset abandons any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      mask_q      <= '0;
      base_q      <= VEC_RST;
      vec_q       <= '0;
      id_q        <= '0;
      irq_q       <= 1'b0;
      vec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      base_q      <= base_d;
      vec_q       <= vec_d;
      id_q        <= id_d;
      irq_q       <= irq_d;
      vec_valid_q <= vec_valid_d;
    end
  end

  // Read mux; the status view puts in_service at bit 4 above a 4-bit id field.
  always_comb begin
    cr_rdata = '0;
    case (cr_sel)
      SEL_MASK: cr_rdata[NSRC-1:0] = mask_q;
      SEL_BASE: cr_rdata = base_q;
      SEL_EOI: begin
        cr_rdata[4]   = (state_q == ST_SERV);
        cr_rdata[3:0] = 4'(id_q);
      end
      SEL_PEND: cr_rdata[NSRC-1:0] = pend_q;
      default:  cr_rdata = '0;
    endcase
  end

  assign irq       = irq_q;
  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then random traffic.
// A cycle-level reference model is compared against the DUT after every rising edge.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  src = '0;
  logic        cr_we = 1'b0;
  logic [1:0]  cr_sel = '0;
  logic [15:0] cr_wdata = '0;
  logic [15:0] cr_rdata;
  logic        irq;
  logic        int_ack = 1'b0;
  logic [15:0] vec;
  logic        vec_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(8), .VEC_RST(16'h0100)) dut (
    .clk       (clk),
    .reset     (reset),
    .src       (src),
    .cr_we     (cr_we),
    .cr_sel    (cr_sel),
    .cr_wdata  (cr_wdata),
    .cr_rdata  (cr_rdata),
    .irq       (irq),
    .int_ack   (int_ack),
    .vec       (vec),
    .vec_valid (vec_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_REQ = 1, M_SERV = 2;
  int          m_st;
  logic [7:0]  m_pend, m_mask, m_elig, m_clr, m_rise;
  logic [15:0] m_base, m_vec;
  int          m_id, m_n, m_nst, m_first;
  logic        m_vv;
  logic [7:0]  h1, h2, h3;   // src as sampled 1, 2, 3 edges ago

  // A rise sampled at edge k is in PEND after edge k+2; nothing counts until
  // the line has been sampled twice since reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st = M_IDLE; m_pend = 0; m_mask = 0; m_base = 16'h0100;
      m_vec = 0; m_id = 0; m_vv = 0; m_n = 0; h1 = 0; h2 = 0; h3 = 0;
    end else begin
      if (m_n < 100) m_n = m_n + 1;
      m_rise = (m_n >= 4) ? (h2 & ~h3) : 8'h00;
      h3 = h2; h2 = h1; h1 = src;
      m_elig = m_pend & m_mask;
      m_clr = 0; m_vv = 0; m_nst = m_st;
      if (m_st == M_IDLE) begin
        if (m_elig != 0) m_nst = M_REQ;
      end else if (m_st == M_REQ) begin
        if (int_ack && m_elig != 0) begin
          m_first = -1;
          for (int k = 0; k < 8; k++) if (m_first < 0 && m_elig[k]) m_first = k;
          m_id = m_first;
          m_clr[m_first] = 1'b1;
          m_vec = m_base + 16'(4 * m_first);
          m_vv = 1;
          m_nst = M_SERV;
        end else if (m_elig == 0) m_nst = M_IDLE;
      end else begin
        if (cr_we && cr_sel == 2'd2) m_nst = M_IDLE;
      end
      if (cr_we && cr_sel == 2'd0) m_mask = cr_wdata[7:0];
      if (cr_we && cr_sel == 2'd1) m_base = cr_wdata & 16'hFFFC;
      if (cr_we && cr_sel == 2'd3) m_clr = m_clr | cr_wdata[7:0];
      m_pend = (m_pend & ~m_clr) | m_rise;
      m_st = m_nst;
    end
  end

  function automatic logic [15:0] m_rdata(input logic [1:0] sel);
    case (sel)
      2'd0:    return {8'h00, m_mask};
      2'd1:    return m_base;
      2'd2:    return {11'b0, (m_st == M_SERV), 4'(m_id)};
      default: return {8'h00, m_pend};
    endcase
  endfunction

  // Continuous comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("cyc_irq", irq, (m_st == M_REQ));
    chk("cyc_vec_valid", vec_valid, m_vv);
    chk("cyc_vec", vec, m_vec);
    chk("cyc_rdata", cr_rdata, m_rdata(cr_sel));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [1:0] sel, input logic [15:0] d);
    @(negedge clk); cr_we = 1'b1; cr_sel = sel; cr_wdata = d;
    @(negedge clk); cr_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [15:0] exp, input string name);
    @(negedge clk); cr_sel = sel;
    #1 chk(name, cr_rdata, exp);
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk); src = src | b;
    repeat (3) @(negedge clk);
    src = src & ~b;
  endtask

  task automatic do_ack();
    @(negedge clk); int_ack = 1'b1;
    @(negedge clk); int_ack = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int budget);
    int k = 0;
    while (irq !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, irq, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_irq", irq, 0);
    chk("rst_vec", vec, 0);
    chk("rst_base", cr_rdata, 16'h0000);  // cr_sel = MASK
    reset = 1'b1;
    repeat (5) @(negedge clk);
    rd(2'd1, 16'h0100, "rst_base_val");

    // Basic request on source 3.
    wr(2'd0, 16'h00FF);
    pulse(8'h08);
    wait_irq("t1_irq", 1);
    do_ack();
    chk("t1_vv", vec_valid, 1);
    chk("t1_vec", vec, 16'h010C);
    @(negedge clk);
    chk("t1_vv_drop", vec_valid, 0);
    rd(2'd2, 16'h0013, "t1_status");
    wr(2'd2, 16'h0000);
    rd(2'd2, 16'h0003, "t1_after_eoi");

    // Sources 5 and 1 together: 1 first, then 5 after EOI.
    @(negedge clk); src = 8'h22;
    repeat (3) @(negedge clk); src = 8'h00;
    wait_irq("t2_irq_a", 4);
    do_ack();
    chk("t2_vec_a", vec, 16'h0104);
    rd(2'd3, 16'h0020, "t2_pend");
    wr(2'd2, 16'h0000);
    wait_irq("t2_irq_b", 4);
    do_ack();
    chk("t2_vec_b", vec, 16'h0114);
    wr(2'd2, 16'h0000);

    // Masked source stays pending until enabled.
    wr(2'd0, 16'h0000);
    pulse(8'h04);
    repeat (4) @(negedge clk);
    chk("t3_irq_masked", irq, 0);
    rd(2'd3, 16'h0004, "t3_pend");
    wr(2'd0, 16'h0004);
    chk("t3_irq_pre", irq, 0);
    @(negedge clk);
    chk("t3_irq_rise", irq, 1);
    do_ack();
    chk("t3_vec", vec, 16'h0108);
    wr(2'd2, 16'h0000);

    // Withdrawn request, then a stray ack.
    wr(2'd0, 16'h00FF);
    pulse(8'h01);
    wait_irq("t4_irq", 4);
    wr(2'd0, 16'h0000);
    @(negedge clk);
    chk("t4_irq_drop", irq, 0);
    do_ack();
    chk("t4_stray_vv", vec_valid, 0);
    rd(2'd2, 16'h0002, "t4_status");
    rd(2'd3, 16'h0001, "t4_pend");
    wr(2'd3, 16'h00FF);
    rd(2'd3, 16'h0000, "t4_pend_w1c");

    // EOI in IDLE is ignored; BASE low bits are forced to zero.
    wr(2'd2, 16'h0000);
    rd(2'd2, 16'h0002, "t5_eoi_idle");
    wr(2'd1, 16'h0302);
    rd(2'd1, 16'h0300, "t5_base");
    wr(2'd0, 16'h00FF);
    pulse(8'h80);
    wait_irq("t5_irq", 4);
    do_ack();
    chk("t5_vec", vec, 16'h031C);
    wr(2'd2, 16'h0000);
    rd(2'd2, 16'h0007, "t5_status");

    // Asynchronous reset right as service begins; src[6] held through release.
    wr(2'd1, 16'h0100);
    pulse(8'h10);
    wait_irq("t6_irq", 4);
    @(negedge clk); int_ack = 1'b1; cr_sel = 2'd1;
    @(posedge clk);
    #2 reset = 1'b0; int_ack = 1'b0; src = 8'h40;
    #1;
    chk("t6_irq", irq, 0);
    chk("t6_vv", vec_valid, 0);
    chk("t6_vec", vec, 0);
    chk("t6_base", cr_rdata, 16'h0100);
    cr_sel = 2'd2; #1 chk("t6_status", cr_rdata, 16'h0000);
    cr_sel = 2'd0; #1 chk("t6_mask", cr_rdata, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    rd(2'd3, 16'h0000, "t6_no_edge_after_reset");
    src = 8'h00;
    repeat (4) @(negedge clk);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) == 0) src[b] = ~src[b];
      int_ack  = ($urandom_range(0, 3) == 0);
      cr_we    = ($urandom_range(0, 7) == 0);
      cr_sel   = 2'($urandom_range(0, 3));
      cr_wdata = 16'($urandom);
      if (i % 997 == 500) begin
        @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    cr_we = 1'b0; int_ack = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
